// File: rtl/cpu_pkg.sv
// Shared widths, constants and the IF/ID pipeline record for the 32-bit core.
// Imported by the fetch stage and its PC sub-module.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int OPCODE_W  = 6;
    localparam int REG_W     = 5;
    localparam int SHAMT_W   = 5;
    localparam int FUNCT_W   = 6;
    localparam int JADDR_W   = 26;
    localparam int IMM_W     = XLEN / 2;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset value, external load, or +4 advance.
// load has priority over en; with neither asserted the PC holds.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int              N         = XLEN,
    parameter logic [N-1:0]    RESET_VAL = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] pc
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (en) begin
            pc_d = pc_q + N'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_id_stage.sv
// Fetch stage with the IF/ID pipeline register and decode-field slicing.
// Update priority each edge: reset > redirect > stall > imem_ready > bubble.
module fetch_id_stage
    import cpu_pkg::*;
#(
    parameter int           n        = XLEN,
    parameter int           i        = n / 2,
    parameter logic [n-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    output logic [n-1:0]        imem_addr,
    input  logic [n-1:0]        imem_rdata,
    input  logic                imem_ready,
    input  logic                stall,
    input  logic                redirect,
    input  logic [n-1:0]        redirect_pc,
    output logic                id_valid,
    output logic [n-1:0]        id_pc_plus4,
    output logic [n-1:0]        id_instr,
    output logic [OPCODE_W-1:0] id_opcode,
    output logic [REG_W-1:0]    id_rs,
    output logic [REG_W-1:0]    id_rt,
    output logic [REG_W-1:0]    id_rd,
    output logic [SHAMT_W-1:0]  id_shamt,
    output logic [FUNCT_W-1:0]  id_funct,
    output logic [i-1:0]        id_imm16,
    output logic [JADDR_W-1:0]  id_jaddr26
);

    logic [n-1:0] pc;
    logic [n-1:0] pc_plus4;
    logic [n-1:0] redirect_target;
    logic         pc_en;
    logic         accept;

    if_id_t if_id_q;
    if_id_t if_id_d;

    assign redirect_target = redirect_pc & ~n'(3);
    assign accept          = !redirect && !stall && imem_ready;
    assign pc_en           = accept;

    pc_reg #(
        .N         (n),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (pc_en),
        .load     (redirect),
        .load_val (redirect_target),
        .pc       (pc)
    );

    assign imem_addr = pc & ~n'(3);
    // Wraps modulo 2^n by construction; no carry out is kept.
    assign pc_plus4  = pc + n'(4);

    always_comb begin
        if_id_d = if_id_q;
        if (redirect) begin
            if_id_d.valid = 1'b0;
        end else if (stall) begin
            if_id_d = if_id_q;
        end else if (imem_ready) begin
            if_id_d.valid    = 1'b1;
            if_id_d.instr    = imem_rdata;
            if_id_d.pc_plus4 = pc_plus4;
        end else begin
            if_id_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q.valid    <= 1'b0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.instr    <= NOP_INSTR;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    // A bubble or flushed slot always presents a NOP to decode.
    assign id_valid    = if_id_q.valid;
    assign id_pc_plus4 = if_id_q.pc_plus4;
    assign id_instr    = if_id_q.valid ? if_id_q.instr : NOP_INSTR;

    assign id_opcode   = id_instr[31:26];
    assign id_rs       = id_instr[25:21];
    assign id_rt       = id_instr[20:16];
    assign id_rd       = id_instr[15:11];
    assign id_shamt    = id_instr[10:6];
    assign id_funct    = id_instr[5:0];
    assign id_imm16    = id_instr[i-1:0];
    assign id_jaddr26  = id_instr[25:0];

endmodule

// File: tb/tb_fetch_id_stage.sv
// Directed bench for fetch_id_stage: a reference model checked every cycle,
// plus hand-computed expectations after each scenario.
module tb_fetch_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_jaddr26;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_live = 1'b0;

    always #5 clk = ~clk;

    fetch_id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imm16    (id_imm16),
        .id_jaddr26  (id_jaddr26)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the spec's per-edge rules applied to the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_live  = 1'b1;
        end else if (redirect) begin
            m_pc    = redirect_pc - (redirect_pc % 4);
            m_valid = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (imem_ready) begin
            m_pc4   = m_pc + 4;
            m_instr = imem_rdata;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
        end else begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (m_live) begin
            e = m_valid ? m_instr : 32'h0;
            chk("imem_addr",  imem_addr,          m_pc);
            chk("id_valid",   32'(id_valid),      32'(m_valid));
            chk("id_pc_plus4", id_pc_plus4,       m_pc4);
            chk("id_instr",   id_instr,           e);
            chk("id_opcode",  32'(id_opcode),     e >> 26);
            chk("id_rs",      32'(id_rs),         (e >> 21) % 32);
            chk("id_rt",      32'(id_rt),         (e >> 16) % 32);
            chk("id_rd",      32'(id_rd),         (e >> 11) % 32);
            chk("id_shamt",   32'(id_shamt),      (e >> 6) % 32);
            chk("id_funct",   32'(id_funct),      e % 64);
            chk("id_imm16",   32'(id_imm16),      e % 65536);
            chk("id_jaddr26", 32'(id_jaddr26),    e % (1 << 26));
        end
    end

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic rdy, input logic [31:0] data);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = data;
        @(posedge clk);
        #2;
        $display("step reset=%0b stall=%0b redirect=%0b rpc=%h ready=%0b rdata=%h -> addr=%h valid=%0b pc4=%h instr=%h",
                 r, s, rd, rpc, rdy, data, imem_addr, id_valid, id_pc_plus4, id_instr);
    endtask

    initial begin
        logic [31:0] sx;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b1; imem_rdata = 32'h2008_8000;

        // 1: reset for two cycles, then the first word
        step(1, 0, 0, 32'h0, 1, 32'h2008_8000);
        step(1, 0, 0, 32'h0, 1, 32'h2008_8000);
        chk("rst_addr",   imem_addr, 32'h0);
        chk("rst_valid",  32'(id_valid), 32'h0);
        chk("rst_instr",  id_instr, 32'h0);
        chk("rst_pc4",    id_pc_plus4, 32'h0);
        step(0, 0, 0, 32'h0, 1, 32'h2008_8000);
        sx = {{16{id_imm16[15]}}, id_imm16};
        chk("t1_addr",    imem_addr, 32'h4);
        chk("t1_valid",   32'(id_valid), 32'h1);
        chk("t1_pc4",     id_pc_plus4, 32'h4);
        chk("t1_imm16",   32'(id_imm16), 32'h8000);
        chk("t1_signext", sx, 32'hFFFF_8000);
        chk("t1_opcode",  32'(id_opcode), 32'h8);
        chk("t1_rt",      32'(id_rt), 32'h8);

        // 2/3: next word, two stalled cycles, then resume
        step(0, 0, 0, 32'h0, 1, 32'h1111_2222);
        chk("t2_addr",    imem_addr, 32'h8);
        chk("t2_pc4",     id_pc_plus4, 32'h8);
        step(0, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
        step(0, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
        chk("t3_addr",    imem_addr, 32'h8);
        chk("t3_instr",   id_instr, 32'h1111_2222);
        chk("t3_pc4",     id_pc_plus4, 32'h8);
        step(0, 0, 0, 32'h0, 1, 32'h3333_4444);
        chk("t3_resume",  imem_addr, 32'hC);
        chk("t3_pc4b",    id_pc_plus4, 32'hC);

        // 4: redirect overrides stall and flushes
        step(0, 1, 1, 32'h0000_0043, 1, 32'h5555_6666);
        chk("t4_addr",    imem_addr, 32'h40);
        chk("t4_valid",   32'(id_valid), 32'h0);
        chk("t4_instr",   id_instr, 32'h0);

        // 5: R-type word, then three not-ready cycles
        step(0, 0, 0, 32'h0, 1, 32'h012A_4020);
        chk("t5_rd",      32'(id_rd), 32'h8);
        chk("t5_funct",   32'(id_funct), 32'h20);
        chk("t5_rs",      32'(id_rs), 32'h9);
        step(0, 0, 0, 32'h0, 0, 32'h7777_8888);
        step(0, 0, 0, 32'h0, 0, 32'h7777_8888);
        step(0, 0, 0, 32'h0, 0, 32'h7777_8888);
        chk("t5_addr",    imem_addr, 32'h44);
        chk("t5_valid",   32'(id_valid), 32'h0);
        chk("t5_opcode",  32'(id_opcode), 32'h0);

        // 6: redirect to the top word and wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h9999_0000);
        chk("t6_addr",    imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0, 1, 32'h8C22_0004);
        chk("t6_wrap",    imem_addr, 32'h0);
        chk("t6_pc4",     id_pc_plus4, 32'h0);
        chk("t6_valid",   32'(id_valid), 32'h1);
        chk("t6_jaddr",   32'(id_jaddr26), 32'h0022_0004);

        // reset wins over a simultaneous stall and redirect
        step(0, 0, 0, 32'h0, 1, 32'h0);
        step(1, 1, 1, 32'h0000_0100, 1, 32'hAAAA_BBBB);
        chk("rst_mid_addr",  imem_addr, 32'h0);
        chk("rst_mid_valid", 32'(id_valid), 32'h0);
        chk("rst_mid_pc4",   id_pc_plus4, 32'h0);
        step(0, 0, 0, 32'h0, 1, 32'hCAFE_0001);
        chk("post_rst_pc4",  id_pc_plus4, 32'h4);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
